// File: rtl/intcode_io_pkg.sv
// Shared constants for the intcode memory-mapped I/O port.
// Offsets are in words relative to the decoded window base.
package intcode_io_pkg;

  localparam logic [31:0] STATUS_OFS = 32'h0000_0100;
  localparam logic [31:0] WINDOW     = 32'h0000_0200;

  localparam int ERR_BIT   = 31;
  localparam int FLUSH_BIT = 0;
  localparam int NF_BASE   = 16;

  function automatic logic [31:0] in_ofs(input int c);
    return 32'(2 * c);
  endfunction

  function automatic logic [31:0] out_ofs(input int c);
    return 32'(2 * c + 1);
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with flush; head word is visible combinationally.
// Push is refused when full even if a pop happens in the same cycle.
module io_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full & ~i_flush & ~i_reset;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/intcode_io_port.sv
// Bus-side decode for per-channel input/output FIFOs of the intcode system.
// Holds the wait logic, the one-cycle read register and the sticky error flag.
module intcode_io_port
  import intcode_io_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 16,
  parameter int          CHANNELS  = 2,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               address_bus,
  input  logic                      bus_write,
  input  logic                      bus_read,
  input  logic [WIDTH-1:0]          bus_wdata,
  output logic [WIDTH-1:0]          bus_rdata,
  output logic                      bus_rdata_valid,
  output logic                      bus_wait,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready
);

  logic [31:0]         w_offset;
  logic                w_in_window;
  logic                w_is_status;
  logic                w_is_chan;
  logic [CHANNELS-1:0] w_in_sel;
  logic [CHANNELS-1:0] w_out_sel;
  logic [CHANNELS-1:0] w_in_empty;
  logic [CHANNELS-1:0] w_in_full;
  logic [CHANNELS-1:0] w_out_empty;
  logic [CHANNELS-1:0] w_out_full;
  logic [WIDTH-1:0]    w_in_head [CHANNELS];
  logic                w_wr;
  logic                w_rd;
  logic                w_wait;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_flush;
  logic                w_err_evt;
  logic [31:0]         w_status;
  logic [WIDTH-1:0]    w_rd_word;
  logic                r_err;

  // Unsigned subtraction folds addresses below the base into the "outside" range.
  assign w_offset    = address_bus - BASE_ADDR;
  assign w_in_window = (w_offset < WINDOW);
  assign w_is_status = (w_offset == STATUS_OFS);
  assign w_is_chan   = |{w_in_sel, w_out_sel};
  assign w_wr        = w_in_window & bus_write;
  assign w_rd        = w_in_window & bus_read & ~bus_write;
  assign w_wr_acc    = w_wr & ~w_wait;
  assign w_rd_acc    = w_rd & ~w_wait;
  assign w_flush     = w_wr_acc & w_is_status & bus_wdata[FLUSH_BIT];
  assign bus_wait    = w_wait & ~reset;

  assign w_err_evt = w_in_window & (bus_read | bus_write) &
                     (~(w_is_chan | w_is_status) | (bus_read & bus_write) |
                      (w_wr & |w_in_sel) | (w_rd & |w_out_sel));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_in_sel[c]  = (w_offset == in_ofs(c));
    assign w_out_sel[c] = (w_offset == out_ofs(c));
    assign in_ready[c]  = ~w_in_full[c];
    assign out_valid[c] = ~w_out_empty[c];

    io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .i_clock (clock),
      .i_reset (reset),
      .i_flush (w_flush),
      .i_push  (in_valid[c]),
      .i_pop   (w_rd_acc & w_in_sel[c]),
      .i_wdata (in_data[c*WIDTH +: WIDTH]),
      .o_rdata (w_in_head[c]),
      .o_full  (w_in_full[c]),
      .o_empty (w_in_empty[c])
    );

    io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .i_clock (clock),
      .i_reset (reset),
      .i_flush (w_flush),
      .i_push  (w_wr_acc & w_out_sel[c]),
      .i_pop   (out_ready[c]),
      .i_wdata (bus_wdata),
      .o_rdata (out_data[c*WIDTH +: WIDTH]),
      .o_full  (w_out_full[c]),
      .o_empty (w_out_empty[c])
    );
  end

  // Stall only on reads of an empty input FIFO or writes to a full output FIFO.
  always_comb begin
    w_wait = 1'b0;
    if (w_wr) begin
      w_wait = |(w_out_sel & w_out_full);
    end else if (w_rd) begin
      w_wait = |(w_in_sel & w_in_empty);
    end else begin
      w_wait = 1'b0;
    end
  end

  // STATUS image and read-data selection; unmapped reads return zero.
  always_comb begin
    w_status                      = 32'h0000_0000;
    w_status[CHANNELS-1:0]        = ~w_in_empty;
    w_status[NF_BASE +: CHANNELS] = ~w_out_full;
    w_status[ERR_BIT]             = r_err;
    w_rd_word                     = '0;
    if (w_is_status) begin
      w_rd_word = WIDTH'(w_status);
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        w_rd_word = w_rd_word | (w_in_head[c] & {WIDTH{w_in_sel[c]}});
      end
    end
  end

  // Read-data register: valid pulses for exactly one cycle per accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_rdata       <= '0;
      bus_rdata_valid <= 1'b0;
    end else begin
      bus_rdata_valid <= w_rd_acc;
      if (w_rd_acc) begin
        bus_rdata <= w_rd_word;
      end
    end
  end

  // Sticky error; a new error event takes priority over a clear request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_evt && !w_wait) begin
      r_err <= 1'b1;
    end else if (w_wr_acc && w_is_status && bus_wdata[ERR_BIT]) begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_intcode_io_port.sv
// Scoreboard bench for intcode_io_port: bus reads and channel-0 output pops
// are checked against queues filled as stimulus is driven.
module tb_intcode_io_port;

  localparam int          W    = 32;
  localparam int          CH   = 2;
  localparam int          D    = 16;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] STAT = 32'hFFFF_0100;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     address_bus = 32'h0;
  logic            bus_write = 1'b0;
  logic            bus_read = 1'b0;
  logic [W-1:0]    bus_wdata = '0;
  logic [W-1:0]    bus_rdata;
  logic            bus_rdata_valid;
  logic            bus_wait;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] out_q[$];

  intcode_io_port #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .address_bus(address_bus),
    .bus_write(bus_write), .bus_read(bus_read), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid), .bus_wait(bus_wait),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog");
  end

  // Read-data scoreboard and channel-0 output stream scoreboard.
  always begin
    @(negedge clock);
    #2;
    if (bus_rdata_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: actual valid with data %h, required no read result", bus_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus_rdata !== e) begin
          errors++;
          $display("FAIL rdata: actual %h, required %h", bus_rdata, e);
        end
      end
    end
    if (out_valid[0] && out_ready[0]) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: actual pop of %h, required empty stream", out_data[W-1:0]);
      end else begin
        logic [31:0] e;
        e = out_q.pop_front();
        if (out_data[W-1:0] !== e) begin
          errors++;
          $display("FAIL out_data: actual %h, required %h", out_data[W-1:0], e);
        end
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with the strobe dropped.
  task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp, output int waits);
    address_bus = addr;
    bus_read    = 1'b1;
    waits       = 0;
    #1;
    while (bus_wait && waits < 200) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (bus_wait) begin
      errors++;
      $display("FAIL read_timeout: actual wait still high at %h, required release", addr);
    end else begin
      exp_q.push_back(exp);
    end
    @(negedge clock);
    bus_read = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, output int waits);
    address_bus = addr;
    bus_wdata   = data;
    bus_write   = 1'b1;
    waits       = 0;
    #1;
    while (bus_wait && waits < 200) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (bus_wait) begin
      errors++;
      $display("FAIL write_timeout: actual wait still high at %h, required release", addr);
    end
    @(negedge clock);
    bus_write = 1'b0;
  endtask

  task automatic push_in(input int c, input logic [31:0] data);
    in_data[c*W +: W] = data;
    in_valid[c]       = 1'b1;
    #1;
    checks++;
    if (in_ready[c] !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: actual %b, required 1 on channel %0d", in_ready[c], c);
    end
    @(negedge clock);
    in_valid[c] = 1'b0;
  endtask

  task automatic test_reset();
    int w;
    @(negedge clock);
    address_bus = BASE;
    bus_read    = 1'b1;
    #1;
    checks++;
    if (bus_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait: actual %b, required 0", bus_wait);
    end
    repeat (2) @(negedge clock);
    bus_read = 1'b0;
    reset    = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, bus_rdata_valid} !== 5'b11000 || bus_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: actual ready %b valid %b rv %b rdata %h, required 11 00 0 0",
               in_ready, out_valid, bus_rdata_valid, bus_rdata);
    end
    @(negedge clock);
    cpu_read(STAT, 32'h0003_0000, w);
  endtask

  task automatic test_in_basic();
    int w;
    push_in(0, 32'd5);
    push_in(0, 32'd7);
    push_in(0, 32'd9);
    for (int i = 0; i < 3; i++) begin
      cpu_read(BASE, 32'(5 + 2 * i), w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL in_basic_wait: actual %0d wait cycles, required 0", w);
      end
    end
  endtask

  task automatic test_wait_release();
    address_bus = BASE + 32'd2;
    bus_read    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus_wait !== 1'b1) begin
        errors++;
        $display("FAIL empty_wait: actual %b, required 1", bus_wait);
      end
      @(negedge clock);
    end
    in_data[W +: W] = 32'd42;
    in_valid[1]     = 1'b1;
    #1;
    checks++;
    if (bus_wait !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass_wait: actual %b, required 1", bus_wait);
    end
    @(negedge clock);
    in_valid[1] = 1'b0;
    #1;
    checks++;
    if (bus_wait !== 1'b0) begin
      errors++;
      $display("FAIL wait_release: actual %b, required 0", bus_wait);
    end else begin
      exp_q.push_back(32'd42);
    end
    @(negedge clock);
    bus_read = 1'b0;
  endtask

  task automatic test_out_full();
    int w;
    for (int i = 1; i <= D; i++) begin
      cpu_write(BASE + 32'd1, 32'(i), w);
      if (w == 0) out_q.push_back(32'(i));
    end
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[W-1:0] !== 32'd1) begin
      errors++;
      $display("FAIL out_head: actual valid %b data %h, required 1 and 1", out_valid[0], out_data[W-1:0]);
    end
    cpu_read(STAT, 32'h0002_0000, w);
    address_bus = BASE + 32'd1;
    bus_wdata   = 32'd17;
    bus_write   = 1'b1;
    #1;
    checks++;
    if (bus_wait !== 1'b1) begin
      errors++;
      $display("FAIL full_wait: actual %b, required 1", bus_wait);
    end
    out_ready[0] = 1'b1;
    @(negedge clock);
    out_ready[0] = 1'b0;
    #1;
    checks++;
    if (bus_wait !== 1'b0) begin
      errors++;
      $display("FAIL full_release: actual %b, required 0", bus_wait);
    end else begin
      out_q.push_back(32'd17);
    end
    @(negedge clock);
    bus_write    = 1'b0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (!out_valid[0]) break;
    end
    out_ready[0] = 1'b0;
    checks++;
    if (out_q.size() != 0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL drain: actual %0d words left valid %b, required 0 and 0", out_q.size(), out_valid[0]);
    end
    @(negedge clock);
  endtask

  task automatic test_wrap();
    int w;
    int guard;
    for (int i = 0; i < D; i++) push_in(0, 32'(100 + i));
    in_data[W-1:0] = 32'd116;
    in_valid[0]    = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: actual %b, required 0", in_ready[0]);
    end
    @(negedge clock);
    address_bus = BASE;
    bus_read    = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || bus_wait !== 1'b0) begin
      errors++;
      $display("FAIL pop_cycle_ready: actual ready %b wait %b, required 0 0", in_ready[0], bus_wait);
    end
    exp_q.push_back(32'd100);
    @(negedge clock);
    bus_read = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_pop: actual %b, required 1", in_ready[0]);
    end
    guard = 0;
    fork
      begin
        for (int i = D; i < 40; i++) begin
          in_data[W-1:0] = 32'(100 + i);
          in_valid[0]    = 1'b1;
          while (!in_ready[0] && guard < 500) begin
            @(negedge clock);
            #1;
            guard++;
          end
          @(negedge clock);
          #1;
        end
        in_valid[0] = 1'b0;
      end
      begin
        @(negedge clock);
        for (int k = 1; k < 40; k++) cpu_read(BASE, 32'(100 + k), w);
      end
    join
    checks++;
    if (guard >= 500) begin
      errors++;
      $display("FAIL wrap_producer: actual %0d stalled cycles, required fewer than 500", guard);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_error_flush();
    int w;
    push_in(1, 32'd200);
    push_in(1, 32'd201);
    for (int i = 0; i < 3; i++) cpu_write(BASE + 32'd3, 32'(300 + i), w);
    cpu_read(BASE - 32'd1, 32'h0, w);
    exp_q.pop_back();
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL outside_wait: actual %0d wait cycles, required 0", w);
    end
    cpu_read(STAT, 32'h0003_0002, w);
    cpu_read(BASE + 32'h50, 32'h0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL unmapped_wait: actual %0d wait cycles, required 0", w);
    end
    cpu_read(STAT, 32'h8003_0002, w);
    cpu_write(STAT, 32'h8000_0001, w);
    #1;
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 2'b11) begin
      errors++;
      $display("FAIL flush: actual out_valid %b in_ready %b, required 00 11", out_valid, in_ready);
    end
    @(negedge clock);
    cpu_read(STAT, 32'h0003_0000, w);
    address_bus = BASE + 32'd1;
    bus_wdata   = 32'd77;
    bus_write   = 1'b1;
    bus_read    = 1'b1;
    out_q.push_back(32'd77);
    @(negedge clock);
    bus_write = 1'b0;
    bus_read  = 1'b0;
    cpu_read(STAT, 32'h8003_0000, w);
    out_ready[0] = 1'b1;
    @(negedge clock);
    out_ready[0] = 1'b0;
    cpu_write(STAT, 32'h8000_0000, w);
    cpu_read(STAT, 32'h0003_0000, w);
  endtask

  task automatic test_reset_mid();
    int w;
    for (int i = 0; i < 3; i++) push_in(0, 32'(400 + i));
    for (int i = 0; i < 3; i++) cpu_write(BASE + 32'd1, 32'(500 + i), w);
    address_bus = BASE;
    bus_read    = 1'b1;
    reset       = 1'b1;
    #1;
    checks++;
    if (bus_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: actual %b, required 0", bus_wait);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 2'b00 || bus_rdata_valid !== 1'b0 || in_ready !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_state: actual out_valid %b rv %b in_ready %b, required 00 0 11",
               out_valid, bus_rdata_valid, in_ready);
    end
    checks++;
    if (bus_wait !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read: actual wait %b, required 1", bus_wait);
    end
    @(negedge clock);
    bus_read = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_in_basic();
    test_wait_release();
    test_out_full();
    test_wrap();
    test_error_flush();
    test_reset_mid();
    repeat (2) @(negedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: actual %0d reads %0d pops outstanding, required 0 0", exp_q.size(), out_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
